// File: rtl/psum_drain_ctrl_if.sv
// Bundle of the psum read port (memctrl0) and the downstream word stream.
// master: drain controller side; slave: memory controller + consumer side.
//   memctrl0_radd/rden  read request      memctrl0_odat/ovld  read return
//   o_dat/o_vld         output word       i_rdy               consumer ready
interface psum_drain_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] memctrl0_radd;
    logic                  memctrl0_rden;
    logic [DATA_WIDTH-1:0] memctrl0_odat;
    logic                  memctrl0_ovld;
    logic [DATA_WIDTH-1:0] o_dat;
    logic                  o_vld;
    logic                  i_rdy;

    modport master (
        output memctrl0_radd,
        output memctrl0_rden,
        input  memctrl0_odat,
        input  memctrl0_ovld,
        output o_dat,
        output o_vld,
        input  i_rdy
    );

    modport slave (
        input  memctrl0_radd,
        input  memctrl0_rden,
        output memctrl0_odat,
        output memctrl0_ovld,
        input  o_dat,
        input  o_vld,
        output i_rdy
    );
endinterface

// File: rtl/psum_drain_ctrl.sv
// Drains accumulated partial sums from psum memory in address order,
// applies optional per-lane ReLU and streams words out via valid/ready.
// Ports: clk, rst (sync, active high), i_start pulse, i_conf_* config,
//   bus (memctrl0 read port + output stream), o_busy, o_done (level).
module psum_drain_ctrl #(
    parameter int BIT_WIDTH  = 8,
    parameter int REG_WIDTH  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DELAY  = 1,
    parameter int NUM_KERNEL = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [REG_WIDTH-1:0] i_conf_ctrl,
    input  logic [REG_WIDTH-1:0] i_conf_outputsize,
    input  logic [REG_WIDTH-1:0] i_conf_kernelshape,
    psum_drain_ctrl_if.master    bus,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
    localparam bit CFG_OK = (FIFO_DEPTH >= MEM_DELAY + 2) &&
                            (DATA_WIDTH == NUM_KERNEL * BIT_WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state;
    logic [15:0]           groups_q;
    logic [REG_WIDTH-1:0]  last_w_q;
    logic                  relu_q;
    logic [REG_WIDTH-1:0]  wcnt;
    logic [15:0]           gcnt;
    logic [ADDR_WIDTH-1:0] radd_q;
    logic [CW-1:0]         outst;
    logic [CW-1:0]         outst_nxt;
    logic [CW-1:0]         fcnt;
    logic [CW-1:0]         fcnt_nxt;
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] push_dat;

    logic start_ok;
    logic credit;
    logic rden;
    logic last_addr;
    logic push;
    logic pop;
    logic full;
    logic unused_cfg;

    assign unused_cfg = ^{i_conf_ctrl[REG_WIDTH-1:6], i_conf_ctrl[4:0],
                          i_conf_kernelshape[17:0]};

    assign start_ok = i_start && (state == S_IDLE || state == S_DONE);

    // Credit counts both in-flight reads and buffered words, so every
    // returning word is guaranteed a free FIFO slot.
    assign credit = ({1'b0, outst} + {1'b0, fcnt}) < DEPTH_C;
    assign rden   = (state == S_READ) && credit;

    assign last_addr = (gcnt == groups_q - 16'd1) && (wcnt == last_w_q);

    // With nothing outstanding, a return must belong to a pass that was
    // cut short by reset; it is dropped.
    assign push = bus.memctrl0_ovld && (outst != '0);
    assign full = ({1'b0, fcnt} == DEPTH_C);
    assign pop  = (fcnt != '0) && bus.i_rdy;

    always_comb begin
        push_dat = bus.memctrl0_odat;
        if (relu_q) begin
            for (int k = 0; k < NUM_KERNEL; k++) begin
                if (bus.memctrl0_odat[BIT_WIDTH*(k+1)-1])
                    push_dat[BIT_WIDTH*k +: BIT_WIDTH] = '0;
            end
        end
    end

    always_comb begin
        outst_nxt = outst;
        if (rden && !push)
            outst_nxt = outst + CW'(1);
        else if (!rden && push)
            outst_nxt = outst - CW'(1);
    end

    always_comb begin
        fcnt_nxt = fcnt;
        if (push && !pop)
            fcnt_nxt = fcnt + CW'(1);
        else if (!push && pop)
            fcnt_nxt = fcnt - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            groups_q <= '0;
            last_w_q <= '0;
            relu_q   <= 1'b0;
            wcnt     <= '0;
            gcnt     <= '0;
            radd_q   <= '0;
            outst    <= '0;
            fcnt     <= '0;
            wptr     <= '0;
            rptr     <= '0;
        end else begin
            outst <= outst_nxt;
            fcnt  <= fcnt_nxt;
            if (push)
                wptr <= wptr + PW'(1);
            if (pop)
                rptr <= rptr + PW'(1);

            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        groups_q <= {2'b00, i_conf_kernelshape[31:18]};
                        last_w_q <= i_conf_outputsize;
                        relu_q   <= i_conf_ctrl[5];
                        wcnt     <= '0;
                        gcnt     <= '0;
                        radd_q   <= '0;
                        if (i_conf_kernelshape[31:18] == '0)
                            state <= S_DONE;
                        else
                            state <= S_READ;
                    end
                end
                S_READ: begin
                    if (rden) begin
                        radd_q <= radd_q + ADDR_WIDTH'(1);
                        if (last_addr) begin
                            state <= S_DRAIN;
                        end else if (wcnt == last_w_q) begin
                            wcnt <= '0;
                            gcnt <= gcnt + 16'd1;
                        end else begin
                            wcnt <= wcnt + REG_WIDTH'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // Look at next-cycle counts so o_done rises right
                    // after the final handshake.
                    if (outst_nxt == '0 && fcnt_nxt == '0)
                        state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.memctrl0_radd = radd_q;
    assign bus.memctrl0_rden = rden;
    assign bus.o_vld         = (fcnt != '0);
    assign bus.o_dat         = (fcnt != '0) ? fifo_mem[rptr] : '0;
    assign o_busy            = (state == S_READ) || (state == S_DRAIN);
    assign o_done            = (state == S_DONE);

    a_cfg: assert property (@(posedge clk) CFG_OK);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && full));

endmodule

// File: tb/tb_psum_drain_ctrl.sv
// Bench for psum_drain_ctrl: table of drain passes, reset corner case
// and randomized passes checked against a queue-based reference model.
module tb_psum_drain_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [31:0] conf_ctrl;
    logic [31:0] conf_os;
    logic [31:0] conf_ks;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    psum_drain_ctrl_if bus ();

    psum_drain_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .i_start            (i_start),
        .i_conf_ctrl        (conf_ctrl),
        .i_conf_outputsize  (conf_os),
        .i_conf_kernelshape (conf_ks),
        .bus                (bus),
        .o_busy             (busy),
        .o_done             (done)
    );

    logic [31:0] mem [256];

    // Memory with one cycle of read latency; not reset, so a read issued
    // just before reset still returns afterwards.
    always @(posedge clk) begin
        bus.memctrl0_ovld <= bus.memctrl0_rden;
        bus.memctrl0_odat <= mem[bus.memctrl0_radd[7:0]];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] relu_ref(input logic [31:0] w,
                                             input bit en);
        logic [31:0] r;
        int unsigned lane;
        r = 0;
        for (int k = 0; k < 4; k++) begin
            lane = (w >> (8 * k)) & 255;
            if (en && lane >= 128)
                lane = 0;
            r = r | (32'(lane) << (8 * k));
        end
        return r;
    endfunction

    function automatic logic rdy_of(input int mode, input int cyc);
        case (mode)
            0: return 1'b1;
            1: return (cyc % 2) == 0;
            2: return $urandom_range(0, 9) < 7;
            default: return cyc >= 20;
        endcase
    endfunction

    task automatic fill_mem(input int kind);
        for (int a = 0; a < 256; a++) begin
            case (kind)
                0: mem[a] = 32'(a);
                1: mem[a] = $urandom;
                default: mem[a] = (a == 0) ? 32'h80FF017F : 32'(a);
            endcase
        end
    endtask

    typedef struct {
        int          os;
        int          kern;
        bit          relu;
        int          mode;
        int          mem_kind;
        int          exp_words;
        bit          chk_first;
        logic [31:0] exp_first;
    } vec_t;

    vec_t vecs[7];

    task automatic start_pass(input vec_t v);
        @(negedge clk);
        conf_ctrl = v.relu ? 32'h20 : 32'h0;
        conf_os   = 32'(v.os);
        conf_ks   = 32'(v.kern) << 16;
        i_start   = 1'b1;
        @(negedge clk);
        i_start   = 1'b0;
    endtask

    task automatic run_pass(input vec_t v, input string tag);
        logic [31:0] q[$];
        logic [31:0] prev_dat;
        bit          prev_stall;
        bit          finished;
        int total, cyc, reads, pops, nxt_addr;
        int first_rd, first_vld, last_hs, done_cyc;

        fill_mem(v.mem_kind);
        total = (v.kern / 4) * (v.os + 1);
        for (int a = 0; a < total; a++)
            q.push_back(relu_ref(mem[a], v.relu));

        start_pass(v);
        cyc = 0; reads = 0; pops = 0; nxt_addr = 0;
        first_rd = -1; first_vld = -1; last_hs = -1; done_cyc = -1;
        prev_stall = 0; prev_dat = 0; finished = 0;

        while (!finished && cyc < 600) begin
            bus.i_rdy = rdy_of(v.mode, cyc);
            if (done) begin
                finished = 1;
                done_cyc = cyc;
            end else begin
                if (bus.memctrl0_rden) begin
                    check({tag, "_radd"}, bus.memctrl0_radd, nxt_addr);
                    nxt_addr++;
                    reads++;
                    if (first_rd < 0) first_rd = cyc;
                    check({tag, "_credit"}, (reads - pops) <= 4, 1);
                end
                if (v.mode == 3 && cyc == 19)
                    check({tag, "_stall_reads"}, reads, 4);
                if (prev_stall)
                    check({tag, "_hold"}, bus.o_dat, prev_dat);
                if (bus.o_vld && first_vld < 0)
                    first_vld = cyc;
                if (bus.o_vld && bus.i_rdy) begin
                    if (q.size() == 0) begin
                        check({tag, "_extra_word"}, bus.o_dat, 64'hx);
                    end else begin
                        if (pops == 0 && v.chk_first)
                            check({tag, "_first"}, bus.o_dat, v.exp_first);
                        check({tag, "_data"}, bus.o_dat, q.pop_front());
                    end
                    pops++;
                    last_hs = cyc;
                end
                prev_stall = bus.o_vld && !bus.i_rdy;
                prev_dat   = bus.o_dat;
                @(negedge clk);
                cyc++;
            end
        end

        check({tag, "_timeout"}, finished, 1);
        check({tag, "_words"}, pops, v.exp_words);
        check({tag, "_leftover"}, q.size(), 0);
        if (total > 0)
            check({tag, "_done_lat"}, done_cyc - last_hs, 1);
        else
            check({tag, "_done_lat0"}, done_cyc, 0);
        if (total > 0 && v.mode == 0)
            check({tag, "_first_lat"}, first_vld - first_rd, 2);
        check({tag, "_busy_end"}, busy, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({tag, "_post_rden"}, bus.memctrl0_rden, 0);
            check({tag, "_post_vld"}, bus.o_vld, 0);
            check({tag, "_post_done"}, done, 1);
        end
    endtask

    vec_t rv;

    initial begin
        rst = 1'b1; i_start = 1'b0;
        conf_ctrl = 0; conf_os = 0; conf_ks = 0;
        bus.i_rdy = 1'b0;
        fill_mem(0);

        vecs[0] = '{3, 8, 0, 0, 0, 8, 1, 32'h0};
        vecs[1] = '{3, 8, 0, 1, 0, 8, 1, 32'h0};
        vecs[2] = '{0, 4, 1, 0, 2, 1, 1, 32'h0000017F};
        vecs[3] = '{15, 4, 0, 3, 0, 16, 1, 32'h0};
        vecs[4] = '{3, 2, 0, 0, 0, 0, 0, 32'h0};
        vecs[5] = '{1, 12, 1, 2, 1, 6, 0, 32'h0};
        vecs[6] = '{4, 16, 1, 2, 1, 20, 0, 32'h0};

        repeat (3) @(negedge clk);
        check("rst_rden", bus.memctrl0_rden, 0);
        check("rst_radd", bus.memctrl0_radd, 0);
        check("rst_vld", bus.o_vld, 0);
        check("rst_dat", bus.o_dat, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            run_pass(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a pass with reads in flight.
        fill_mem(0);
        start_pass('{15, 4, 0, 3, 0, 16, 0, 32'h0});
        bus.i_rdy = 1'b0;
        @(negedge clk);
        check("mid_rden", bus.memctrl0_rden, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_rden", bus.memctrl0_rden, 0);
        check("mid_rst_radd", bus.memctrl0_radd, 0);
        check("mid_rst_vld", bus.o_vld, 0);
        check("mid_rst_dat", bus.o_dat, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        check("late_ovld_vld", bus.o_vld, 0);
        check("late_ovld_dat", bus.o_dat, 0);
        run_pass(vecs[0], "after_rst");

        for (int i = 0; i < 6; i++) begin
            rv.os        = $urandom_range(0, 7);
            rv.kern      = $urandom_range(0, 24);
            rv.relu      = 1'($urandom_range(0, 1));
            rv.mode      = 2;
            rv.mem_kind  = 1;
            rv.exp_words = (rv.kern / 4) * (rv.os + 1);
            rv.chk_first = 0;
            rv.exp_first = 0;
            run_pass(rv, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/psum_drain_ctrl.md
Name: psum_drain_ctrl

Overview:
- Reads the accumulated partial sums back out of the psum accumulator memory once accumulation is done.
- Drives the same memctrl0 read port that the accumulator uses, but from the other side: it issues reads at a fixed latency and streams packed kernel words downstream over a valid/ready interface.
- Sits between the psum memory controller and the output writeback / DMA path. Optional per-lane ReLU is applied on the way out.

Parameters:
- BIT_WIDTH, 8, width of one kernel lane.
- REG_WIDTH, 32, width of configuration registers.
- DATA_WIDTH, 32, memory word width; equals NUM_KERNEL*BIT_WIDTH.
- ADDR_WIDTH, 32, memory address width.
- MEM_DELAY, 1, cycles from memctrl0_rden to memctrl0_ovld.
- NUM_KERNEL, 4, kernel lanes per memory word.
- FIFO_DEPTH, 4, output skid FIFO entries; must be >= MEM_DELAY+2, power of 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_start  in  1  single-cycle pulse; begins a drain pass
- i_conf_ctrl  in  REG_WIDTH  bit5 = ReLU enable
- i_conf_outputsize  in  REG_WIDTH  words per kernel group minus 1
- i_conf_kernelshape  in  REG_WIDTH  [31:16] = total kernel count
- memctrl0_radd  out  ADDR_WIDTH  read address
- memctrl0_rden  out  1  read request
- memctrl0_odat  in  DATA_WIDTH  read data
- memctrl0_ovld  in  1  read data valid
- o_dat  out  DATA_WIDTH  output word; lane k = bits [BIT_WIDTH*(k+1)-1 : BIT_WIDTH*k]
- o_vld  out  1  output valid
- i_rdy  in  1  downstream ready
- o_busy  out  1  high whenever state is not IDLE/DONE
- o_done  out  1  level; pass complete

Behaviour:
- Reset values: memctrl0_rden=0, memctrl0_radd=0, o_vld=0, o_dat=0, o_busy=0, o_done=0. FIFO is empty, all counters are 0, state is IDLE.
- Configuration is sampled into registers on the i_start cycle and held for the whole pass:
  - groups = kernelshape[31:16] >> 2
  - words_per_group = outputsize + 1
  - relu = ctrl[5]
- Address map: group g, word w maps to address g*(outputsize+1)+w. Reads are issued strictly ascending from 0, generated with word and group counters; no multiplier.
- State machine IDLE -> READ -> DRAIN -> DONE:
  - IDLE, i_start: latch config, clear o_done. If groups==0, go directly to DONE; otherwise go to READ.
  - READ: memctrl0_rden=1 only when credit holds: outstanding + fifo_count < FIFO_DEPTH. Each issued read increments radd. Issuing the last address (g=groups-1, w=outputsize) moves to DRAIN.
  - DRAIN: no reads. Move to DONE when outstanding==0, FIFO is empty, and no handshake is in flight.
  - DONE: o_done=1. i_start clears o_done and restarts as from IDLE.
- Outstanding counter:
  - +1 on rden, -1 on ovld; both in the same cycle leaves it unchanged.
  - Width is clog2(FIFO_DEPTH)+1.
- FIFO:
  - Written on memctrl0_ovld with data after ReLU. With relu=1, any lane whose MSB is set is replaced by 0, lanes are independent. With relu=0, data passes through.
  - Simultaneous push and pop keeps the count unchanged.
  - Credit rule guarantees no overflow. An ovld arriving when the FIFO is full is a protocol error: flag it with an assertion only.
- Output:
  - o_vld = FIFO not empty; o_dat = FIFO head (first-word fall-through).
  - Handshake on o_vld & i_rdy pops one entry.
  - o_dat holds while o_vld=1 and i_rdy=0.
- Latency: with i_rdy held high, the first o_vld occurs MEM_DELAY+1 cycles after the first rden. Full rate is sustained at 1 word/cycle.
- i_start while busy is ignored.
- rst mid-pass returns everything to reset values immediately. Any ovld returned after reset is dropped.
- Total words per pass = groups*(outputsize+1). Each is emitted exactly once, in address order.

Test Plan:
- Preload mem[a]=a, outputsize=3, kernels=8, relu=0, i_rdy=1, start → addresses 0..7 read, o_dat = 0..7 back-to-back, o_done high 1 cycle after last handshake, rden never asserted again.
- Same setup, i_rdy toggling 1010… → 8 words in order, no drops or duplicates, o_dat stable while stalled, outstanding+fifo_count never exceeds 4.
- mem[0]=0x80FF017F, relu=1, outputsize=0, kernels=4 → single word 0x0000017F.
- i_rdy=0 for 20 cycles after start, outputsize=15, kernels=4 → exactly 4 reads issued then rden stalls; on release all 16 words delivered in order.
- kernels=2 (groups=0), start → o_done=1 next cycle, no rden, no o_vld.
- rst asserted while 2 reads outstanding, mid-pass → all outputs return to 0 next cycle; late ovld ignored; a new start then drains from address 0 correctly.
